i2c_slave_ctrl: RTL and testbench

Single-address I2C target (responder) for the far end of our I2C master link. It oversamples the bus on the system clock and detects START and STOP conditions. It matches a fixed 7-bit address, ACKs it, and then either delivers written bytes to local logic or serves read bytes fetched from local logic. SDA is driven open-drain through an output-enable; the block never drives SCL and never stretches the clock.

---
 rtl/i2c_slave_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_ctrl.sv
// Single-address I2C target: oversampled START/STOP detection, address match with ACK,
// write bytes delivered on rx_valid, read bytes fetched via tx_req. Open-drain SDA via sda_oe.
module i2c_slave_ctrl #(
  parameter logic [6:0] SLV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
  logic                done_q, done_d;   // byte complete (ADDR/WRITE) or master ACK seen (RD_ACK)
  logic                rw_q, rw_d;
  logic                sda_oe_q, sda_oe_d;
  logic                rx_valid_q, rx_valid_d;
  logic                tx_req_q, tx_req_d;
  logic                busy_q, busy_d;

  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;
  logic scl_rise_c, scl_fall_c, start_c, stop_c;

  // Two-flop synchronisers plus history flops; idle bus level is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_h_q <= 1'b1;
      sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_h_q <= 1'b1;
    end else begin
      scl_s1_q <= scl_in;   scl_s2_q <= scl_s1_q; scl_h_q <= scl_s2_q;
      sda_s1_q <= sda_in;   sda_s2_q <= sda_s1_q; sda_h_q <= sda_s2_q;
    end
  end

  assign scl_rise_c = scl_s2_q & ~scl_h_q;
  assign scl_fall_c = ~scl_s2_q & scl_h_q;
  assign start_c    = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_c     = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd7;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      done_q     <= 1'b0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      done_q     <= done_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    done_d     = done_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;

    if (stop_c) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      done_d    = 1'b0;
      bit_cnt_d = 3'd7;
    end else if (start_c) begin
      state_d   = ADDR;
      sda_oe_d  = 1'b0;
      done_d    = 1'b0;
      bit_cnt_d = 3'd7;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR, WRITE: begin
          if (scl_rise_c) begin
            shift_d   = {shift_q[6:0], sda_s2_q};
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) done_d = 1'b1;
          end else if (scl_fall_c && done_q) begin
            done_d    = 1'b0;
            bit_cnt_d = 3'd7;
            if (state_q == WRITE) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              sda_oe_d   = 1'b1;
              state_d    = WR_ACK;
            end else if (shift_q[7:1] == SLV_ADDR) begin
              sda_oe_d = 1'b1;
              rw_d     = shift_q[0];
              tx_req_d = shift_q[0];
              state_d  = ADDR_ACK;
            end else begin
              state_d = IDLE;
            end
          end
        end
        ADDR_ACK, WR_ACK: begin
          if (scl_fall_c) begin
            bit_cnt_d = 3'd7;
            done_d    = 1'b0;
            if (state_q == ADDR_ACK && rw_q) begin
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[7];
              state_d  = READ;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WRITE;
            end
          end
        end
        READ: begin
          // bit_cnt tracks the bit currently on the bus; shift_q[7] is that bit
          if (scl_fall_c) begin
            if (bit_cnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              done_d   = 1'b0;
              state_d  = RD_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise_c) begin
            if (!sda_s2_q) begin
              tx_req_d = 1'b1;
              done_d   = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else if (scl_fall_c && done_q) begin
            done_d    = 1'b0;
            bit_cnt_d = 3'd7;
            shift_d   = tx_data;
            sda_oe_d  = ~tx_data[7];
            state_d   = READ;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign sda_oe   = sda_oe_q;
  assign tx_req   = tx_req_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: bit-banged I2C master on a wired-AND SDA, checked against
// transaction-level expectations (address match, byte queues, pulse counts).
module tb_i2c_slave_ctrl;

  localparam int unsigned HALF = 16;
  localparam logic [6:0] MY_ADDR = 7'h50;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_drv, sda_drv, sda_bus;
  logic       sda_oe, tx_req, rx_valid, busy;
  logic [7:0] tx_data, rx_data;

  int checks = 0;
  int failures = 0;
  int rxv_cnt = 0, txr_cnt = 0, overlap_cnt = 0;
  logic oe_seen = 1'b0, busy_low = 1'b0;
  logic [7:0] rx_log[$];
  logic [7:0] tx_q[$];

  assign sda_bus = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_ctrl #(.SLV_ADDR(MY_ADDR)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_drv), .sda_in(sda_bus), .sda_oe(sda_oe),
    .tx_data(tx_data), .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  // Local-logic side: log received bytes, answer tx_req from the queue
  always @(negedge clk) begin
    if (rx_valid) begin rxv_cnt++; rx_log.push_back(rx_data); end
    if (tx_req) begin
      txr_cnt++;
      tx_data = (tx_q.size() > 0) ? tx_q.pop_front() : 8'($urandom);
    end
    if (rx_valid && tx_req) overlap_cnt++;
    if (sda_oe) oe_seen = 1'b1;
    if (!busy) busy_low = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_drv = 1'b1; tick(HALF/2);
    scl_drv = 1'b1; tick(HALF/2);
    sda_drv = 1'b0; tick(HALF/2);
    scl_drv = 1'b0; tick(HALF/2);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; tick(HALF/2);
    scl_drv = 1'b1; tick(HALF/2);
    sda_drv = 1'b1; tick(HALF);
  endtask

  task automatic clk_bit(input logic b, output logic smp);
    sda_drv = b;    tick(HALF/2);
    scl_drv = 1'b1; tick(HALF/2);
    smp = sda_bus;  tick(HALF/2);
    scl_drv = 1'b0; tick(HALF/2);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin clk_bit(1'b1, s); d[i] = s; end
    clk_bit(~master_ack, s);
  endtask

  task automatic test_reset();
    checks++; if (sda_oe !== 1'b0)   begin failures++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (tx_req !== 1'b0)   begin failures++; $display("FAIL reset_tx_req got=%b exp=0", tx_req); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_write();
    logic a0, a1; int rx0;
    rx0 = rxv_cnt; rx_log.delete();
    bus_start();
    write_byte({MY_ADDR, 1'b0}, a0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL write_busy got=%b exp=1", busy); end
    write_byte(8'hA5, a1);
    bus_stop();
    checks++; if (a0 !== 1'b1) begin failures++; $display("FAIL write_addr_ack got=%b exp=1", a0); end
    checks++; if (a1 !== 1'b1) begin failures++; $display("FAIL write_data_ack got=%b exp=1", a1); end
    checks++; if (rxv_cnt - rx0 != 1) begin failures++; $display("FAIL write_rxv_count got=%0d exp=1", rxv_cnt - rx0); end
    checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL write_rx_data got=%h exp=a5", rx_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_after_stop got=%b exp=0", busy); end
  endtask

  task automatic test_mismatch();
    logic a0, a1; int rx0;
    rx0 = rxv_cnt; oe_seen = 1'b0;
    bus_start();
    write_byte({7'h51, 1'b0}, a0);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mismatch_busy got=%b exp=0", busy); end
    write_byte(8'hFF, a1);
    bus_stop();
    checks++; if (a0 !== 1'b0 || a1 !== 1'b0) begin failures++; $display("FAIL mismatch_nack got=%b%b exp=00", a0, a1); end
    checks++; if (oe_seen !== 1'b0) begin failures++; $display("FAIL mismatch_oe_seen got=%b exp=0", oe_seen); end
    checks++; if (rxv_cnt != rx0) begin failures++; $display("FAIL mismatch_rxv got=%0d exp=0", rxv_cnt - rx0); end
  endtask

  task automatic test_read();
    logic a0; logic [7:0] d0, d1; int tr0;
    tr0 = txr_cnt; tx_q.delete(); tx_q.push_back(8'h3C); tx_q.push_back(8'hC3);
    bus_start();
    write_byte({MY_ADDR, 1'b1}, a0);
    read_byte(1'b1, d0);
    read_byte(1'b0, d1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL read_busy_after_nack got=%b exp=0", busy); end
    bus_stop();
    checks++; if (a0 !== 1'b1)  begin failures++; $display("FAIL read_addr_ack got=%b exp=1", a0); end
    checks++; if (d0 !== 8'h3C) begin failures++; $display("FAIL read_byte0 got=%h exp=3c", d0); end
    checks++; if (d1 !== 8'hC3) begin failures++; $display("FAIL read_byte1 got=%h exp=c3", d1); end
    checks++; if (txr_cnt - tr0 != 2) begin failures++; $display("FAIL read_txreq_count got=%0d exp=2", txr_cnt - tr0); end
  endtask

  task automatic test_back_to_back();
    logic a0, a1, a2; logic [7:0] d0;
    tx_q.delete(); tx_q.push_back(8'h5A);
    bus_start();
    write_byte({MY_ADDR, 1'b0}, a0);
    write_byte(8'h12, a1);
    busy_low = 1'b0;
    bus_start();
    write_byte({MY_ADDR, 1'b1}, a2);
    checks++; if (busy_low !== 1'b0) begin failures++; $display("FAIL restart_busy_dropped got=%b exp=0", busy_low); end
    read_byte(1'b0, d0);
    bus_stop();
    checks++; if (rx_data !== 8'h12) begin failures++; $display("FAIL restart_rx_data got=%h exp=12", rx_data); end
    checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL restart_acks got=%b exp=111", {a0, a1, a2}); end
    checks++; if (d0 !== 8'h5A) begin failures++; $display("FAIL restart_read got=%h exp=5a", d0); end
  endtask

  task automatic test_partial_stop();
    logic a0, s; logic [7:0] d; int rx0;
    rx0 = rxv_cnt;
    bus_start();
    write_byte({MY_ADDR, 1'b0}, a0);
    for (int i = 0; i < 4; i++) clk_bit(1'($urandom), s);
    bus_stop();
    checks++; if (rxv_cnt != rx0) begin failures++; $display("FAIL partial_rxv got=%0d exp=0", rxv_cnt - rx0); end
    checks++; if (sda_oe !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL partial_idle got oe=%b busy=%b exp=0 0", sda_oe, busy); end
    d = 8'($urandom);
    bus_start();
    write_byte({MY_ADDR, 1'b0}, a0);
    write_byte(d, a0);
    bus_stop();
    checks++; if (rxv_cnt - rx0 != 1 || rx_data !== d) begin failures++; $display("FAIL partial_next_write got=%h cnt=%0d exp=%h cnt=1", rx_data, rxv_cnt - rx0, d); end
  endtask

  task automatic test_reset_ack();
    logic s, a0; int rx0;
    bus_start();
    for (int i = 7; i >= 0; i--) clk_bit(MY_ADDR[i > 0 ? i - 1 : 0] & (i > 0), s);
    checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL rstack_pre_oe got=%b exp=1", sda_oe); end
    rst = 1'b1; #2;
    checks++; if (sda_oe !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstack_async got oe=%b busy=%b exp=0 0", sda_oe, busy); end
    tick(2); rst = 1'b0;
    rx0 = rxv_cnt; oe_seen = 1'b0;
    clk_bit(1'b1, s);
    write_byte(8'h3E, a0);
    checks++; if (oe_seen !== 1'b0 || rxv_cnt != rx0 || busy !== 1'b0) begin failures++; $display("FAIL rstack_ignored got oe=%b rxv=%0d busy=%b exp=0 0 0", oe_seen, rxv_cnt - rx0, busy); end
    bus_stop();
  endtask

  task automatic test_random();
    logic [6:0] addr; logic rw, ack, match; int n, rx0, tr0;
    logic [7:0] d, bytes[$], got;
    for (int t = 0; t < 20; t++) begin
      addr = ($urandom_range(0, 1) == 0) ? MY_ADDR : 7'($urandom);
      rw = 1'($urandom); n = $urandom_range(1, 3);
      match = (addr == MY_ADDR);
      rx0 = rxv_cnt; tr0 = txr_cnt; rx_log.delete(); bytes.delete(); tx_q.delete();
      for (int k = 0; k < n; k++) bytes.push_back(8'($urandom));
      if (rw && match) tx_q = bytes;
      bus_start();
      write_byte({addr, rw}, ack);
      checks++; if (ack !== match) begin failures++; $display("FAIL rand_addr_ack t=%0d got=%b exp=%b", t, ack, match); end
      for (int k = 0; k < n; k++) begin
        if (!rw) begin
          write_byte(bytes[k], ack);
          checks++; if (ack !== match) begin failures++; $display("FAIL rand_data_ack t=%0d got=%b exp=%b", t, ack, match); end
        end else begin
          read_byte(k != n - 1, got);
          d = match ? bytes[k] : 8'hFF;
          checks++; if (got !== d) begin failures++; $display("FAIL rand_read t=%0d k=%0d got=%h exp=%h", t, k, got, d); end
        end
      end
      bus_stop();
      checks++;
      if (rw) begin
        if (txr_cnt - tr0 != (match ? n : 0)) begin failures++; $display("FAIL rand_txreq t=%0d got=%0d exp=%0d", t, txr_cnt - tr0, match ? n : 0); end
      end else begin
        if (rx_log.size() != (match ? n : 0) || (match && rx_log != bytes)) begin failures++; $display("FAIL rand_rx t=%0d got_cnt=%0d exp_cnt=%0d", t, rx_log.size(), match ? n : 0); end
      end
    end
    checks++; if (overlap_cnt != 0) begin failures++; $display("FAIL pulse_overlap got=%0d exp=0", overlap_cnt); end
  endtask

  initial begin
    rst = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1; tx_data = 8'h00;
    tick(4);
    test_reset();
    rst = 1'b0;
    tick(4);
    test_write();
    test_mismatch();
    test_read();
    test_back_to_back();
    test_partial_stop();
    test_reset_ack();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
